mult_issue_ctrl: RTL

Upstream issue stage for the 16x16 signed multiplier (vdic_dut_2023). It buffers operand pairs from a valid/ready source and generates argument parity. It drives the multiplier's req/ack handshake, waits for result_rdy, then checks result parity. Each completed transaction is presented as one record on a valid/ready output, with a timeout guard against a hung multiplier.

---
 rtl/mult_issue_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_issue_ctrl.sv
// Issue controller for the 16x16 signed multiplier: buffers operand pairs, runs the
// req/ack/result_rdy handshake with a timeout guard and emits one checked record per transaction.
module mult_issue_ctrl #(
    parameter int unsigned IN_FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_force_par_err,
    output logic [15:0] arg_a,
    output logic        arg_a_parity,
    output logic [15:0] arg_b,
    output logic        arg_b_parity,
    output logic        req,
    input  logic        ack,
    input  logic [31:0] result,
    input  logic        result_parity,
    input  logic        result_rdy,
    input  logic        arg_parity_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_arg_err,
    output logic        out_res_par_err,
    output logic        out_timeout,
    output logic        busy,
    output logic [15:0] txn_cnt
);
    localparam int unsigned PTR_W = $clog2(IN_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ENT_W = 33;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RDY, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   fifo_mem [IN_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENT_W-1:0]   head;
    logic               push_c, pop_c, tmo_hit, do_capture, do_abort;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               in_ready_q, in_ready_d, busy_q, busy_d;
    logic               req_q, req_d;
    logic [15:0]        arg_a_q, arg_a_d, arg_b_q, arg_b_d;
    logic               arg_a_par_q, arg_a_par_d, arg_b_par_q, arg_b_par_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_result_q, out_result_d;
    logic               out_arg_err_q, out_arg_err_d;
    logic               out_res_par_err_q, out_res_par_err_d;
    logic               out_timeout_q, out_timeout_d;
    logic [15:0]        txn_q, txn_d;

    assign push_c  = in_valid && in_ready_q;
    assign head    = fifo_mem[rd_ptr_q];
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    // Entry layout: {force_par_err, a, b}
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= {in_force_par_err, in_a, in_b};
        end
    end

    // Transaction sequencing; the timeout counter spans REQ and WAIT_RDY
    always_comb begin
        state_d           = state_q;
        pop_c             = 1'b0;
        do_capture        = 1'b0;
        do_abort          = 1'b0;
        tmo_d             = tmo_q;
        req_d             = req_q;
        arg_a_d           = arg_a_q;
        arg_b_d           = arg_b_q;
        arg_a_par_d       = arg_a_par_q;
        arg_b_par_d       = arg_b_par_q;
        out_valid_d       = out_valid_q;
        out_result_d      = out_result_q;
        out_arg_err_d     = out_arg_err_q;
        out_res_par_err_d = out_res_par_err_q;
        out_timeout_d     = out_timeout_q;
        txn_d             = txn_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c       = 1'b1;
                    arg_a_d     = head[31:16];
                    arg_b_d     = head[15:0];
                    arg_a_par_d = (^head[31:16]) ^ head[32];
                    arg_b_par_d = ^head[15:0];
                    req_d       = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (ack && result_rdy) begin
                    do_capture = 1'b1;
                end else if (tmo_hit) begin
                    do_abort = 1'b1;
                end else if (ack) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (result_rdy) begin
                    do_capture = 1'b1;
                end else if (tmo_hit) begin
                    do_abort = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    txn_d       = txn_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_capture) begin
            req_d             = 1'b0;
            out_valid_d       = 1'b1;
            out_result_d      = result;
            out_arg_err_d     = arg_parity_error;
            out_res_par_err_d = (^result) != result_parity;
            out_timeout_d     = 1'b0;
            state_d           = S_OUT;
        end
        if (do_abort) begin
            req_d             = 1'b0;
            out_valid_d       = 1'b1;
            out_result_d      = '0;
            out_arg_err_d     = 1'b0;
            out_res_par_err_d = 1'b0;
            out_timeout_d     = 1'b1;
            state_d           = S_OUT;
        end
    end

    assign in_ready_d = (count_d != CNT_W'(IN_FIFO_DEPTH));
    assign busy_d     = (state_d != S_IDLE) || (count_d != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            tmo_q             <= '0;
            in_ready_q        <= 1'b1;
            busy_q            <= 1'b0;
            req_q             <= 1'b0;
            arg_a_q           <= '0;
            arg_b_q           <= '0;
            arg_a_par_q       <= 1'b0;
            arg_b_par_q       <= 1'b0;
            out_valid_q       <= 1'b0;
            out_result_q      <= '0;
            out_arg_err_q     <= 1'b0;
            out_res_par_err_q <= 1'b0;
            out_timeout_q     <= 1'b0;
            txn_q             <= '0;
        end else begin
            state_q           <= state_d;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(push_c);
            rd_ptr_q          <= rd_ptr_q + PTR_W'(pop_c);
            count_q           <= count_d;
            tmo_q             <= tmo_d;
            in_ready_q        <= in_ready_d;
            busy_q            <= busy_d;
            req_q             <= req_d;
            arg_a_q           <= arg_a_d;
            arg_b_q           <= arg_b_d;
            arg_a_par_q       <= arg_a_par_d;
            arg_b_par_q       <= arg_b_par_d;
            out_valid_q       <= out_valid_d;
            out_result_q      <= out_result_d;
            out_arg_err_q     <= out_arg_err_d;
            out_res_par_err_q <= out_res_par_err_d;
            out_timeout_q     <= out_timeout_d;
            txn_q             <= txn_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign busy            = busy_q;
    assign req             = req_q;
    assign arg_a           = arg_a_q;
    assign arg_b           = arg_b_q;
    assign arg_a_parity    = arg_a_par_q;
    assign arg_b_parity    = arg_b_par_q;
    assign out_valid       = out_valid_q;
    assign out_result      = out_result_q;
    assign out_arg_err     = out_arg_err_q;
    assign out_res_par_err = out_res_par_err_q;
    assign out_timeout     = out_timeout_q;
    assign txn_cnt         = txn_q;

endmodule
